// File: rtl/bcd_clock_counter.sv
// Four-digit BCD MM:SS counter for one chess-clock channel: up/down, preset load, zero/expiry flags.
// Optional Fischer increment input BONUS is enabled by defining BCD_CLOCK_COUNTER_BONUS_EN.
module bcd_clock_counter #(
  parameter int MIN_TENS_MAX = 5,
  parameter bit SAT_AT_ZERO  = 1'b1,
  parameter int BONUS_SEC    = 5
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       IMPULSE,
  input  logic       DIR,
  input  logic       LOAD,
`ifdef BCD_CLOCK_COUNTER_BONUS_EN
  input  logic       BONUS,
`endif
  input  logic [3:0] LD_MIN_TENS,
  input  logic [3:0] LD_MIN_UNITS,
  input  logic [3:0] LD_SEC_TENS,
  input  logic [3:0] LD_SEC_UNITS,
  output logic [3:0] MIN_TENS,
  output logic [3:0] MIN_UNITS,
  output logic [3:0] SEC_TENS,
  output logic [3:0] SEC_UNITS,
  output logic       ZERO,
  output logic       OVERFLOW,
  output logic       EXPIRED
);

  if (MIN_TENS_MAX < 1 || MIN_TENS_MAX > 9 || BONUS_SEC < 1 || BONUS_SEC > 59) begin : g_bad_cfg
    $error("bcd_clock_counter: MIN_TENS_MAX must be 1..9 and BONUS_SEC 1..59");
  end

  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

  logic [3:0] min_tens_q, min_units_q, sec_tens_q, sec_units_q;
  logic [3:0] min_tens_d, min_units_d, sec_tens_d, sec_units_d;
  logic       overflow_q, overflow_d;
  logic       expired_q, expired_d;
  logic       tick, is_zero, is_one, is_max;

  assign tick    = CE & IMPULSE;
  assign is_zero = (min_tens_q == 4'd0) && (min_units_q == 4'd0) &&
                   (sec_tens_q == 4'd0) && (sec_units_q == 4'd0);
  assign is_one  = (min_tens_q == 4'd0) && (min_units_q == 4'd0) &&
                   (sec_tens_q == 4'd0) && (sec_units_q == 4'd1);
  assign is_max  = (min_tens_q == MT_MAX) && (min_units_q == 4'd9) &&
                   (sec_tens_q == 4'd5) && (sec_units_q == 4'd9);

`ifdef BCD_CLOCK_COUNTER_BONUS_EN
  localparam int MAX_SEC = MIN_TENS_MAX * 600 + 599;
  int cur_sec, new_sec;
  assign cur_sec = int'(min_tens_q) * 600 + int'(min_units_q) * 60 +
                   int'(sec_tens_q) * 10 + int'(sec_units_q);
`endif

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    min_tens_d  = min_tens_q;
    min_units_d = min_units_q;
    sec_tens_d  = sec_tens_q;
    sec_units_d = sec_units_q;
    overflow_d  = 1'b0;
    expired_d   = expired_q;
`ifdef BCD_CLOCK_COUNTER_BONUS_EN
    new_sec     = 0;
`endif
    if (LOAD) begin
      min_tens_d  = (LD_MIN_TENS  > MT_MAX) ? MT_MAX : LD_MIN_TENS;
      min_units_d = (LD_MIN_UNITS > 4'd9)   ? 4'd9   : LD_MIN_UNITS;
      sec_tens_d  = (LD_SEC_TENS  > 4'd5)   ? 4'd5   : LD_SEC_TENS;
      sec_units_d = (LD_SEC_UNITS > 4'd9)   ? 4'd9   : LD_SEC_UNITS;
      expired_d   = 1'b0;
    end
`ifdef BCD_CLOCK_COUNTER_BONUS_EN
    // Bonus folds a coincident tick into one saturating add in linear seconds.
    else if (BONUS && !expired_q) begin
      new_sec = cur_sec + BONUS_SEC + ((tick && !DIR) ? 1 : 0) - ((tick && DIR) ? 1 : 0);
      if (new_sec > MAX_SEC) new_sec = MAX_SEC;
      min_tens_d  = 4'(new_sec / 600);
      min_units_d = 4'((new_sec % 600) / 60);
      sec_tens_d  = 4'((new_sec % 60) / 10);
      sec_units_d = 4'(new_sec % 10);
    end
`endif
    else if (tick) begin
      if (DIR) begin
        if (is_zero) begin
          if (!SAT_AT_ZERO) begin
            min_tens_d  = MT_MAX;
            min_units_d = 4'd9;
            sec_tens_d  = 4'd5;
            sec_units_d = 4'd9;
            overflow_d  = 1'b1;
          end
        end else begin
          if (is_one) expired_d = 1'b1;
          if (sec_units_q != 4'd0) sec_units_d = sec_units_q - 4'd1;
          else begin
            sec_units_d = 4'd9;
            if (sec_tens_q != 4'd0) sec_tens_d = sec_tens_q - 4'd1;
            else begin
              sec_tens_d = 4'd5;
              if (min_units_q != 4'd0) min_units_d = min_units_q - 4'd1;
              else begin
                min_units_d = 4'd9;
                min_tens_d  = min_tens_q - 4'd1;
              end
            end
          end
        end
      end else begin
        if (is_max) begin
          min_tens_d  = 4'd0;
          min_units_d = 4'd0;
          sec_tens_d  = 4'd0;
          sec_units_d = 4'd0;
          overflow_d  = 1'b1;
        end else if (sec_units_q != 4'd9) sec_units_d = sec_units_q + 4'd1;
        else begin
          sec_units_d = 4'd0;
          if (sec_tens_q != 4'd5) sec_tens_d = sec_tens_q + 4'd1;
          else begin
            sec_tens_d = 4'd0;
            if (min_units_q != 4'd9) min_units_d = min_units_q + 4'd1;
            else begin
              min_units_d = 4'd0;
              min_tens_d  = min_tens_q + 4'd1;
            end
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      min_tens_q  <= 4'd0;
      min_units_q <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_units_q <= 4'd0;
      overflow_q  <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      min_tens_q  <= min_tens_d;
      min_units_q <= min_units_d;
      sec_tens_q  <= sec_tens_d;
      sec_units_q <= sec_units_d;
      overflow_q  <= overflow_d;
      expired_q   <= expired_d;
    end
  end

  assign MIN_TENS  = min_tens_q;
  assign MIN_UNITS = min_units_q;
  assign SEC_TENS  = sec_tens_q;
  assign SEC_UNITS = sec_units_q;
  assign ZERO      = is_zero;
  assign OVERFLOW  = overflow_q;
  assign EXPIRED   = expired_q;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Directed self-checking bench for bcd_clock_counter: a default instance (59:59, saturating)
// and a 99:59 wrapping instance share all stimulus.
module tb_bcd_clock_counter;

  logic       clk = 1'b0;
  logic       clr = 1'b0, ce = 1'b0, impulse = 1'b0, dir = 1'b0, load = 1'b0;
  logic       bonus = 1'b0;
  logic [3:0] ld_mt = '0, ld_mu = '0, ld_st = '0, ld_su = '0;

  logic [3:0] mt, mu, st, su, mt9, mu9, st9, su9;
  logic       zero, ovf, expd, zero9, ovf9, expd9;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bcd_clock_counter dut (
    .CLK(clk), .CLR(clr), .CE(ce), .IMPULSE(impulse), .DIR(dir), .LOAD(load),
`ifdef BCD_CLOCK_COUNTER_BONUS_EN
    .BONUS(bonus),
`endif
    .LD_MIN_TENS(ld_mt), .LD_MIN_UNITS(ld_mu), .LD_SEC_TENS(ld_st), .LD_SEC_UNITS(ld_su),
    .MIN_TENS(mt), .MIN_UNITS(mu), .SEC_TENS(st), .SEC_UNITS(su),
    .ZERO(zero), .OVERFLOW(ovf), .EXPIRED(expd)
  );

  bcd_clock_counter #(.MIN_TENS_MAX(9), .SAT_AT_ZERO(1'b0)) dut9 (
    .CLK(clk), .CLR(clr), .CE(ce), .IMPULSE(impulse), .DIR(dir), .LOAD(load),
`ifdef BCD_CLOCK_COUNTER_BONUS_EN
    .BONUS(bonus),
`endif
    .LD_MIN_TENS(ld_mt), .LD_MIN_UNITS(ld_mu), .LD_SEC_TENS(ld_st), .LD_SEC_UNITS(ld_su),
    .MIN_TENS(mt9), .MIN_UNITS(mu9), .SEC_TENS(st9), .SEC_UNITS(su9),
    .ZERO(zero9), .OVERFLOW(ovf9), .EXPIRED(expd9)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] val();
    return {mt, mu, st, su};
  endfunction

  function automatic logic [15:0] val9();
    return {mt9, mu9, st9, su9};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic with_tick);
    {ld_mt, ld_mu, ld_st, ld_su} = v;
    load = 1'b1;
    impulse = with_tick;
    step();
    load = 1'b0;
    impulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      impulse = 1'b1;
      step();
      impulse = 1'b0;
    end
  endtask

  initial begin
    clr = 1'b1;
    step();
    step();
    check("reset_value", val(), 16'h0000);
    check("reset_zero", {15'd0, zero}, 16'd1);
    check("reset_expired", {15'd0, expd}, 16'd0);
    check("reset_overflow", {15'd0, ovf}, 16'd0);
    clr = 1'b0;

    // Countdown from 05:00
    ce = 1'b1;
    dir = 1'b1;
    do_load(16'h0500, 1'b0);
    check("load_0500", val(), 16'h0500);
    ticks(1);
    check("down_first_tick", val(), 16'h0459);
    ticks(298);
    check("down_299", val(), 16'h0001);
    check("not_expired_yet", {15'd0, expd}, 16'd0);
    ticks(1);
    check("down_300", val(), 16'h0000);
    check("expired_set", {15'd0, expd}, 16'd1);
    check("zero_at_end", {15'd0, zero}, 16'd1);
    ticks(1);
    check("sat_hold", val(), 16'h0000);
    check("sat_no_ovf", {15'd0, ovf}, 16'd0);
    check("sat_expired_kept", {15'd0, expd}, 16'd1);
    check("wrap9_down_value", val9(), 16'h9959);
    check("wrap9_down_ovf", {15'd0, ovf9}, 16'd1);
    check("wrap9_expired_kept", {15'd0, expd9}, 16'd1);

    // Counting up leaves EXPIRED set
    dir = 1'b0;
    ticks(1);
    check("up_after_expiry", val(), 16'h0001);
    check("up_keeps_expired", {15'd0, expd}, 16'd1);

    // Up-count wrap at 59:59
    do_load(16'h5958, 1'b0);
    check("load_clears_expired", {15'd0, expd}, 16'd0);
    ticks(1);
    check("up_to_max", val(), 16'h5959);
    ticks(1);
    check("up_wrap_value", val(), 16'h0000);
    check("up_wrap_ovf", {15'd0, ovf}, 16'd1);
    check("dut9_no_wrap", val9(), 16'h6000);
    check("dut9_no_ovf", {15'd0, ovf9}, 16'd0);
    step();
    check("ovf_one_cycle", {15'd0, ovf}, 16'd0);

    // 99:59 wrap on the wide instance
    do_load(16'h9959, 1'b0);
    check("clamp_mt_9959", val(), 16'h5959);
    ticks(1);
    check("wrap9_up_value", val9(), 16'h0000);
    check("wrap9_up_ovf", {15'd0, ovf9}, 16'd1);

    // Clamping and tick-during-load
    do_load(16'h7A6F, 1'b0);
    check("clamp_7A6F", val(), 16'h5959);
    check("clamp9_7A6F", val9(), 16'h7959);
    do_load(16'h1234, 1'b1);
    check("load_with_tick", val(), 16'h1234);

    // CE low freezes the count
    ce = 1'b0;
    ticks(10);
    check("ce_freeze", val(), 16'h1234);
    ce = 1'b1;
    dir = 1'b1;
    ticks(1);
    check("dir_change", val(), 16'h1233);
    do_load(16'h1000, 1'b0);
    ticks(1);
    check("borrow_chain", val(), 16'h0959);
    dir = 1'b0;
    ticks(1);
    check("carry_chain", val(), 16'h1000);

    // CLR beats LOAD
    clr = 1'b1;
    do_load(16'h1234, 1'b1);
    clr = 1'b0;
    check("clr_over_load", val(), 16'h0000);
    check("clr_zero", {15'd0, zero}, 16'd1);

`ifdef BCD_CLOCK_COUNTER_BONUS_EN
    dir = 1'b1;
    do_load(16'h0058, 1'b0);
    bonus = 1'b1;
    step();
    bonus = 1'b0;
    check("bonus_no_tick", val(), 16'h0103);
    do_load(16'h0100, 1'b0);
    bonus = 1'b1;
    ticks(1);
    bonus = 1'b0;
    check("bonus_down_tick", val(), 16'h0104);
    do_load(16'h5957, 1'b0);
    bonus = 1'b1;
    step();
    bonus = 1'b0;
    check("bonus_saturate", val(), 16'h5959);
    check("bonus_no_ovf", {15'd0, ovf}, 16'd0);
    do_load(16'h0001, 1'b0);
    ticks(1);
    bonus = 1'b1;
    step();
    bonus = 1'b0;
    check("bonus_when_expired", val(), 16'h0000);
    bonus = 1'b1;
    do_load(16'h0100, 1'b0);
    bonus = 1'b0;
    check("bonus_with_load", val(), 16'h0100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
